// File: rtl/axi_burst_sram_slave_if.sv
// AXI4 bus bundle between a burst master and the SRAM slave.
// The master modport drives requests; the slave modport answers them.
interface axi_burst_sram_slave_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_burst_sram_slave.sv
// AXI4 burst slave backed by a word-addressed synchronous SRAM.
// One transaction in flight; reads and writes share a single address/beat sequencer.
module axi_burst_sram_slave #(
  parameter int               ID_W      = 8,
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter int               LEN_W     = 4,
  parameter int               DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000
) (
  input logic                   clk,
  input logic                   rst,
  axi_burst_sram_slave_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_RDATA, ST_WDATA, ST_WRESP} state_e;

  state_e              state_q, state_d;
  logic                prio_rd_q, prio_rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic                fixed_q, fixed_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                err_dec_q, err_dec_d;
  logic                err_slv_q, err_slv_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   beat_off;
  logic                beat_in_range;
  logic [IDX_W-1:0]    beat_idx;
  logic                ar_hs, aw_hs, w_hs, beat_is_last;
  logic                unused_ok;

  // Beat address is always addr_q; the window test never wraps because addr >= BASE_ADDR is checked first.
  assign beat_off      = addr_q - BASE_ADDR;
  assign beat_in_range = (addr_q >= BASE_ADDR) && (beat_off < SPAN);
  assign beat_idx      = beat_off[IDX_W+1:2];
  assign beat_is_last  = (beat_q == len_q);
  assign unused_ok     = ^{bus.AWSIZE, bus.ARSIZE, beat_off};

  assign bus.AWREADY = !rst && (state_q == ST_IDLE) && bus.AWVALID && (!bus.ARVALID || !prio_rd_q);
  assign bus.ARREADY = !rst && (state_q == ST_IDLE) && bus.ARVALID && (!bus.AWVALID || prio_rd_q);
  assign bus.WREADY  = !rst && (state_q == ST_WDATA);

  assign ar_hs = bus.ARVALID && bus.ARREADY;
  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;

  assign bus.RID    = rid_q;
  assign bus.RDATA  = rdata_q;
  assign bus.RRESP  = rresp_q;
  assign bus.RLAST  = rlast_q;
  assign bus.RVALID = rvalid_q;
  assign bus.BID    = bid_q;
  assign bus.BRESP  = bresp_q;
  assign bus.BVALID = bvalid_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    fixed_d   = fixed_q;
    rid_d     = rid_q;
    bid_d     = bid_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    err_dec_d = err_dec_q;
    err_slv_d = err_slv_q;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.AWVALID && bus.ARVALID) prio_rd_d = !prio_rd_q;
        if (ar_hs) begin
          rid_d   = bus.ARID;
          addr_d  = bus.ARADDR;
          len_d   = bus.ARLEN;
          fixed_d = (bus.ARBURST == 2'b00);
          beat_d  = '0;
          state_d = ST_RDATA;
        end else if (aw_hs) begin
          bid_d     = bus.AWID;
          addr_d    = bus.AWADDR;
          len_d     = bus.AWLEN;
          fixed_d   = (bus.AWBURST == 2'b00);
          beat_d    = '0;
          err_dec_d = 1'b0;
          err_slv_d = 1'b0;
          state_d   = ST_WDATA;
        end
      end

      ST_RDATA: begin
        if (rvalid_q && bus.RREADY && rlast_q) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          state_d  = ST_IDLE;
        end else if (!rvalid_q || bus.RREADY) begin
          // Fetch the next beat in the same cycle the current one is taken, for 1 beat/cycle.
          rvalid_d = 1'b1;
          rlast_d  = beat_is_last;
          rresp_d  = beat_in_range ? RESP_OKAY : RESP_DECERR;
          rdata_d  = beat_in_range ? mem[beat_idx] : '0;
          beat_d   = beat_q + LEN_W'(1);
          if (!fixed_q) addr_d = addr_q + ADDR_W'(4);
        end
      end

      ST_WDATA: begin
        if (w_hs) begin
          mem_we = beat_in_range;
          if (!beat_in_range) err_dec_d = 1'b1;
          if (bus.WLAST != beat_is_last) err_slv_d = 1'b1;
          beat_d = beat_q + LEN_W'(1);
          if (!fixed_q) addr_d = addr_q + ADDR_W'(4);
          if (beat_is_last) begin
            bvalid_d = 1'b1;
            bresp_d  = err_dec_d ? RESP_DECERR : (err_slv_d ? RESP_SLVERR : RESP_OKAY);
            state_d  = ST_WRESP;
          end
        end
      end

      ST_WRESP: begin
        if (bus.BREADY) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prio_rd_q <= 1'b1;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      fixed_q   <= 1'b0;
      rid_q     <= '0;
      bid_q     <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      err_dec_q <= 1'b0;
      err_slv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      fixed_q   <= fixed_d;
      rid_q     <= rid_d;
      bid_q     <= bid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      err_dec_q <= err_dec_d;
      err_slv_q <= err_slv_d;
    end
  end

  // NOTE: the SRAM array has no reset; its contents survive rst and map onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.WSTRB[i]) mem[beat_idx][8*i +: 8] <= bus.WDATA[8*i +: 8];
      end
    end
  end
endmodule
